// File: rtl/light_pkg.sv
// rtl/light_pkg.sv - mode encodings, default PWM constants and mode sequencing helper
package light_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_t;

  localparam int DEFAULT_PWM_BITS  = 8;
  localparam int DEFAULT_PRESCALE  = 100;
  localparam int DEFAULT_DUTY_LOW  = 26;
  localparam int DEFAULT_DUTY_MID  = 128;
  localparam int DEFAULT_DUTY_HIGH = 256;

  // OFF -> LOW -> MID -> HIGH -> OFF
  function automatic mode_t mode_advance(input mode_t m);
    mode_t r;
    case (m)
      MODE_OFF: r = MODE_LOW;
      MODE_LOW: r = MODE_MID;
      MODE_MID: r = MODE_HIGH;
      default:  r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/light_pwm_gen.sv
// rtl/light_pwm_gen.sv - prescaled PWM period counter with registered duty compare
module light_pwm_gen #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 100
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_restart,
  input  logic [PWM_BITS:0] i_duty,
  output logic              o_led
);

  // PRESCALE of 1 still needs a one-bit register that simply stays at 0.
  localparam int                PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Prescaler and period counter; a restart begins a fresh period on the same edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (i_restart) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (presc == PRESC_MAX) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  // Registered output; the extra compare bit lets duty = 2^PWM_BITS mean always on
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_led <= 1'b0;
    end else begin
      o_led <= i_enable && ({1'b0, pwm_cnt} < i_duty);
    end
  end

endmodule

// File: rtl/light_mode_pwm.sv
// rtl/light_mode_pwm.sv - lamp mode FSM driving a PWM LED; LIGHT_AUTO_OFF_EN adds an idle auto-off timer
module light_mode_pwm
  import light_pkg::*;
#(
  parameter int          PWM_BITS        = DEFAULT_PWM_BITS,
  parameter int          PRESCALE        = DEFAULT_PRESCALE,
  parameter int          DUTY_LOW        = DEFAULT_DUTY_LOW,
  parameter int          DUTY_MID        = DEFAULT_DUTY_MID,
  parameter int          DUTY_HIGH       = DEFAULT_DUTY_HIGH,
  parameter logic [31:0] AUTO_OFF_CYCLES = 32'd600_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_next,
  input  logic       i_btn_off,
  output logic       o_led,
  output logic [1:0] o_mode,
  output logic       o_mode_change
);

  localparam int                 DUTY_W = PWM_BITS + 1;
  localparam logic [DUTY_W-1:0]  DUTY_L = DUTY_W'(DUTY_LOW);
  localparam logic [DUTY_W-1:0]  DUTY_M = DUTY_W'(DUTY_MID);
  localparam logic [DUTY_W-1:0]  DUTY_H = DUTY_W'(DUTY_HIGH);

  mode_t             mode;
  mode_t             mode_next;
  logic              mode_changed;
  logic [DUTY_W-1:0] duty;
  logic              expire;

`ifdef LIGHT_AUTO_OFF_EN
  logic [31:0] idle_cnt;

  assign expire = (mode != MODE_OFF) && (idle_cnt == AUTO_OFF_CYCLES - 32'd1);

  // Idle timer: cleared by any button activity or while heading to / sitting in OFF
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_cnt <= '0;
    end else if (i_btn_next || i_btn_off || (mode_next == MODE_OFF)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  logic unused_auto_off;

  assign expire          = 1'b0;
  assign unused_auto_off = ^AUTO_OFF_CYCLES;
`endif

  // Next mode: off beats next, and any button beats timer expiry
  always_comb begin
    mode_next = mode;
    if (i_btn_off) begin
      mode_next = MODE_OFF;
    end else if (i_btn_next) begin
      mode_next = mode_advance(mode);
    end else if (expire) begin
      mode_next = MODE_OFF;
    end
    mode_changed = (mode_next != mode);
  end

  // Mode register and its one-cycle change pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode          <= MODE_OFF;
      o_mode_change <= 1'b0;
    end else begin
      mode          <= mode_next;
      o_mode_change <= mode_changed;
    end
  end

  // Duty lookup from the registered mode, so the LED follows o_mode by one cycle
  always_comb begin
    duty = '0;
    case (mode)
      MODE_LOW:  duty = DUTY_L;
      MODE_MID:  duty = DUTY_M;
      MODE_HIGH: duty = DUTY_H;
      default:   duty = '0;
    endcase
  end

  assign o_mode = mode;

  light_pwm_gen #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_pwm (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (mode != MODE_OFF),
    .i_restart (mode_changed),
    .i_duty    (duty),
    .o_led     (o_led)
  );

endmodule

// File: tb/tb_light_mode_pwm.sv
// tb/tb_light_mode_pwm.sv - scoreboard bench for light_mode_pwm; LIGHT_AUTO_OFF_EN enables the auto-off checks
module tb_light_mode_pwm;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_btn_next;
  logic       i_btn_off;
  logic       o_led;
  logic [1:0] o_mode;
  logic       o_mode_change;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] mode;
    logic       chg;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_mode = 2'd0;
  int         m_idle = 0;
  int         chg_acc = 0;

  light_mode_pwm #(
    .PWM_BITS        (4),
    .PRESCALE        (2),
    .DUTY_LOW        (4),
    .DUTY_MID        (8),
    .DUTY_HIGH       (16),
    .AUTO_OFF_CYCLES (32'd50)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_btn_next    (i_btn_next),
    .i_btn_off     (i_btn_off),
    .o_led         (o_led),
    .o_mode        (o_mode),
    .o_mode_change (o_mode_change)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  // One clock with the given button levels; expected mode/pulse queued at drive time
  task automatic cycle(input logic nx, input logic of);
    logic [1:0] nm;
    logic       old_off;
    exp_t       e;
    bit         exp_fire;
    exp_fire = 1'b0;
`ifdef LIGHT_AUTO_OFF_EN
    exp_fire = !nx && !of && (m_mode != 2'd0) && (m_idle == 49);
`endif
    i_btn_next = nx;
    i_btn_off  = of;
    if (of)            nm = 2'd0;
    else if (nx)       nm = m_mode + 2'd1;
    else if (exp_fire) nm = 2'd0;
    else               nm = m_mode;
    sb.push_back('{mode: nm, chg: (nm != m_mode)});
    old_off = (m_mode == 2'd0);
    m_idle  = (nx || of || nm == 2'd0) ? 0 : m_idle + 1;
    m_mode  = nm;
    @(posedge i_clk);
    #1;
    i_btn_next = 1'b0;
    i_btn_off  = 1'b0;
    e = sb.pop_front();
    check("mode", 32'(o_mode), 32'(e.mode));
    check("mode_change", 32'(o_mode_change), 32'(e.chg));
    if (old_off) check("led_off", 32'(o_led), 32'd0);
    chg_acc += int'(o_mode_change);
  endtask

  task automatic measure(input int n, output int highs, output logic first);
    highs = 0;
    first = 1'b0;
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'b0);
      if (k == 0) first = o_led;
      highs += int'(o_led);
    end
  endtask

  int   h;
  int   n;
  logic f;

  initial begin
    i_reset    = 1'b1;
    i_btn_next = 1'b0;
    i_btn_off  = 1'b0;
    #2;
    check("rst_mode", 32'(o_mode), 32'd0);
    check("rst_led", 32'(o_led), 32'd0);
    check("rst_chg", 32'(o_mode_change), 32'd0);
    #20;
    i_reset = 1'b0;

    // Idle after reset
    repeat (100) cycle(1'b0, 1'b0);

    // Four next pulses 40 cycles apart: 1,2,3,0
    chg_acc = 0;
    for (int p = 0; p < 4; p++) begin
      cycle(1'b1, 1'b0);
      check("seq_mode", 32'(o_mode), 32'((p + 1) % 4));
      repeat (39) cycle(1'b0, 1'b0);
    end
    check("seq_chg_count", 32'(chg_acc), 32'd4);

`ifndef LIGHT_AUTO_OFF_EN
    // Duty per mode over two 32-clock periods
    cycle(1'b1, 1'b0);
    check("low_lag", 32'(o_led), 32'd0);
    measure(32, h, f);
    check("low_first", 32'(f), 32'd1);
    check("low_p1", 32'(h), 32'd8);
    measure(32, h, f);
    check("low_p2", 32'(h), 32'd8);
    cycle(1'b1, 1'b0);
    measure(32, h, f);
    check("mid_first", 32'(f), 32'd1);
    check("mid_p1", 32'(h), 32'd16);
    measure(32, h, f);
    check("mid_p2", 32'(h), 32'd16);
    cycle(1'b1, 1'b0);
    measure(64, h, f);
    check("high_all", 32'(h), 32'd64);
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
`endif

    // Off beats next; off in OFF is silent
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("pre_mid", 32'(o_mode), 32'd2);
    chg_acc = 0;
    cycle(1'b1, 1'b1);
    check("both_mode", 32'(o_mode), 32'd0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("both_chg_count", 32'(chg_acc), 32'd1);

    // Multi-cycle next counts each high cycle
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("hold3_mode", 32'(o_mode), 32'd3);
    repeat (10) cycle(1'b0, 1'b0);
    check("high_led", 32'(o_led), 32'd1);

    // Asynchronous reset between edges
    #2;
    i_reset = 1'b1;
    #1;
    check("async_led", 32'(o_led), 32'd0);
    check("async_mode", 32'(o_mode), 32'd0);
    check("async_chg", 32'(o_mode_change), 32'd0);
    #3;
    i_reset = 1'b0;
    m_mode  = 2'd0;
    m_idle  = 0;
    cycle(1'b1, 1'b0);
    check("post_rst_mode", 32'(o_mode), 32'd1);
    measure(32, h, f);
    check("post_rst_first", 32'(f), 32'd1);
    check("post_rst_p1", 32'(h), 32'd8);
    cycle(1'b0, 1'b1);

`ifdef LIGHT_AUTO_OFF_EN
    // Idle expiry from LOW
    cycle(1'b1, 1'b0);
    n = 0;
    while (o_mode != 2'd0 && n < 200) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("auto_off_delay", 32'(n), 32'd50);
    check("auto_off_chg", 32'(o_mode_change), 32'd1);

    // Button at idle cycle 30 restarts the count
    cycle(1'b1, 1'b0);
    repeat (29) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("auto_restart_mode", 32'(o_mode), 32'd2);
    n = 0;
    while (o_mode != 2'd0 && n < 200) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("auto_restart_delay", 32'(n), 32'd50);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/light_mode_pwm.md
Name: light_mode_pwm

Overview:
- Downstream consumer of the single-cycle release pulses from the button controller.
- Holds the lamp brightness mode: OFF, LOW, MID, HIGH.
- Advances the mode on each "next" pulse and drives a PWM LED output whose duty depends on the current mode.
- Sits between the button controllers and the board LED pin.

Parameters:
- PWM_BITS, 8, width of the PWM period counter; period = PRESCALE * 2^PWM_BITS clocks.
- PRESCALE, 100, clocks per PWM counter step; legal range >= 1.
- DUTY_LOW, 26, high steps per period in LOW; width PWM_BITS+1.
- DUTY_MID, 128, high steps per period in MID.
- DUTY_HIGH, 256, high steps per period in HIGH; a value of 2^PWM_BITS means always on.
- AUTO_OFF_CYCLES, 32'd600_000_000, idle clocks before forced OFF; used only with the optional feature.

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, asynchronous active-high reset.
- i_btn_next, input, 1, one-cycle pulse: advance mode.
- i_btn_off, input, 1, one-cycle pulse: force OFF.
- o_led, output, 1, registered PWM LED drive.
- o_mode, output, 2, current mode: 0 OFF, 1 LOW, 2 MID, 3 HIGH.
- o_mode_change, output, 1, one-cycle pulse when the mode register changes value.

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-period.
  - o_mode=0, o_led=0, o_mode_change=0.
  - Prescaler, PWM counter and idle timer all cleared to 0.
- Mode FSM, evaluated at each rising edge:
  - If i_btn_off=1: next mode is OFF.
  - Else if i_btn_next=1: OFF->LOW->MID->HIGH->OFF (wraps).
  - Else: hold.
  - i_btn_off has priority over i_btn_next when both are high.
  - i_btn_off while already in OFF: no change, no o_mode_change pulse.
  - Inputs are not edge-detected. Each high cycle counts as one event; a 3-cycle-high i_btn_next advances three modes.
- Latency:
  - o_mode and o_mode_change update at the edge that samples the pulse, visible 1 cycle after the pulse.
  - o_led reflects the new duty one cycle after o_mode updates.
- o_mode_change: 1 for exactly one cycle when the mode register value changes; 0 otherwise.
- PWM:
  - Prescaler counts 0..PRESCALE-1 and wraps. The PWM counter increments (mod 2^PWM_BITS) on the cycle the prescaler equals PRESCALE-1.
  - Registered output: o_led <= (mode!=OFF) && ({1'b0,pwm_cnt} < duty(mode)).
  - Compare is unsigned at PWM_BITS+1 width, so duty=2^PWM_BITS gives constant 1.
- Period restart: on any mode change, prescaler and PWM counter reload to 0 in the same edge, so the new mode starts a fresh period.
- In OFF: counters keep running but o_led is forced to 0.

Optional Feature:
- Macro: LIGHT_AUTO_OFF_EN.
- Defined:
  - A 32-bit idle counter increments each cycle while mode!=OFF and no button input is high.
  - Any i_btn_next or i_btn_off high, or entry to OFF, reloads it to 0.
  - When it reaches AUTO_OFF_CYCLES-1, mode goes to OFF at the next edge and o_mode_change pulses; the counter then clears.
  - A button event on the same cycle as expiry wins over expiry.
- Undefined: no timer logic exists; a mode is held indefinitely.

Decomposition:
- Package light_pkg: 2-bit mode encodings MODE_OFF/LOW/MID/HIGH and default duty constants.
- Sub-module light_pwm_gen: prescaler, period counter, comparator and registered output. Inputs are the duty and an enable; a sync-restart input is pulsed on mode change.
- The FSM and optional timer stay in the top module.

Test Plan (all cases use PWM_BITS=4, PRESCALE=2, DUTY_LOW=4, DUTY_MID=8, DUTY_HIGH=16):
- Reset then idle 100 cycles -> o_mode=0, o_led=0, o_mode_change=0 throughout.
- Four i_btn_next pulses spaced 40 cycles apart:
  - o_mode goes 1,2,3,0, each visible 1 cycle after its pulse.
  - o_mode_change pulses 4 times, 1 cycle each.
- LOW held 64 cycles (two periods of 32) -> o_led high exactly 8 cycles per period, starting 2 cycles after the pulse. MID gives 16 high cycles per period; HIGH gives o_led constant 1.
- i_btn_next and i_btn_off high on the same cycle while in MID -> o_mode=0, one o_mode_change pulse. i_btn_off while already OFF -> no pulse.
- Assert i_reset asynchronously mid-cycle while in HIGH with o_led=1 -> o_led and o_mode drop to 0 before the next clock edge. After release, i_btn_next gives LOW with a fresh period.
- With LIGHT_AUTO_OFF_EN and AUTO_OFF_CYCLES=50:
  - Enter LOW and stay idle -> o_mode=0 after 50 cycles, plus a change pulse.
  - A pulse at idle cycle 30 restarts the count, so OFF arrives 50 cycles after that pulse.
